// File: rtl/pong_game_ctrl.sv
// Pong game-control stage: game FSM, BCD score, balls-left count and pause timer.
// All outputs come straight from registers so the text/graphics stages see no input paths.
module pong_game_ctrl #(
   parameter int TIMER_TICKS = 120,
   parameter int BALLS_INIT  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       refr_tick,
   input  logic [1:0] btn,
   input  logic       hit,
   input  logic       miss,
   output logic [3:0] score_dig_0,
   output logic [3:0] score_dig_1,
   output logic [1:0] balls_left_dig,
   output logic       gra_still,
   output logic       rules_en,
   output logic       game_over_en,
   output logic [1:0] game_state
);

   typedef enum logic [1:0] {
      NEWGAME = 2'b00,
      PLAY    = 2'b01,
      NEWBALL = 2'b10,
      OVER    = 2'b11
   } state_t;

   localparam logic [7:0] TICKS = 8'(TIMER_TICKS);
   localparam logic [1:0] BALLS = 2'(BALLS_INIT);

   state_t     state, state_next;
   logic [7:0] timer;
   logic [3:0] dig0, dig1;
   logic [1:0] balls;
   logic       timer_done, timer_load;
   logic       score_inc, score_clr, ball_dec, ball_load;

   assign timer_done = (timer == 8'd0);

   always_comb begin
      state_next = state;
      score_inc  = 1'b0;
      score_clr  = 1'b0;
      ball_dec   = 1'b0;
      ball_load  = 1'b0;
      case (state)
         NEWGAME: begin
            if (btn != 2'b00) begin
               state_next = PLAY;
               ball_dec   = 1'b1;
            end
         end
         PLAY: begin
            // hit and miss in the same cycle both take effect
            score_inc = hit;
            if (miss) begin
               if (balls == 2'd0) begin
                  state_next = OVER;
               end else begin
                  state_next = NEWBALL;
                  ball_dec   = 1'b1;
               end
            end
         end
         NEWBALL: begin
            if (timer_done && btn != 2'b00) state_next = PLAY;
         end
         OVER: begin
            if (timer_done) begin
               state_next = NEWGAME;
               score_clr  = 1'b1;
               ball_load  = 1'b1;
            end
         end
         default: state_next = NEWGAME;
      endcase
   end

   assign timer_load = (state_next != state) && (state_next == NEWBALL || state_next == OVER);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= NEWGAME;
         timer <= 8'd0;
         balls <= BALLS;
         dig0  <= 4'd0;
         dig1  <= 4'd0;
      end else begin
         state <= state_next;

         // load beats a coincident tick
         if (timer_load)                   timer <= TICKS;
         else if (refr_tick && !timer_done) timer <= timer - 8'd1;

         if (ball_load)                         balls <= BALLS;
         else if (ball_dec && balls != 2'd0)    balls <= balls - 2'd1;

         if (score_clr) begin
            dig0 <= 4'd0;
            dig1 <= 4'd0;
         end else if (score_inc) begin
            if (dig0 < 4'd9) begin
               dig0 <= dig0 + 4'd1;
            end else begin
               dig0 <= 4'd0;
               dig1 <= (dig1 < 4'd9) ? dig1 + 4'd1 : 4'd0;
            end
         end
      end
   end

   assign score_dig_0    = dig0;
   assign score_dig_1    = dig1;
   assign balls_left_dig = balls;
   assign gra_still      = (state != PLAY);
   assign rules_en       = (state == NEWGAME);
   assign game_over_en   = (state == OVER);
   assign game_state     = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two instances (default pause, and a one-tick pause with one ball)
// driven by shared stimulus and checked every cycle against an integer-level game model.
module tb_pong_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       refr_tick = 1'b0;
   logic [1:0] btn = 2'b00;
   logic       hit = 1'b0;
   logic       miss = 1'b0;

   logic [3:0] a_d0, a_d1, b_d0, b_d1;
   logic [1:0] a_bl, b_bl, a_gs, b_gs;
   logic       a_still, a_rules, a_over, b_still, b_rules, b_over;

   int total = 0;
   int bad   = 0;

   // model: state 0=new game 1=play 2=new ball 3=over; score 0..99
   int a_st, a_sc, a_bls, a_tm;
   int b_st, b_sc, b_bls, b_tm;

   always #5 clk = ~clk;

   pong_game_ctrl u_a (
      .clk(clk), .rst_n(rst_n), .refr_tick(refr_tick), .btn(btn), .hit(hit), .miss(miss),
      .score_dig_0(a_d0), .score_dig_1(a_d1), .balls_left_dig(a_bl), .gra_still(a_still),
      .rules_en(a_rules), .game_over_en(a_over), .game_state(a_gs)
   );

   pong_game_ctrl #(.TIMER_TICKS(1), .BALLS_INIT(1)) u_b (
      .clk(clk), .rst_n(rst_n), .refr_tick(refr_tick), .btn(btn), .hit(hit), .miss(miss),
      .score_dig_0(b_d0), .score_dig_1(b_d1), .balls_left_dig(b_bl), .gra_still(b_still),
      .rules_en(b_rules), .game_over_en(b_over), .game_state(b_gs)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input int ticks, input int binit, input logic [1:0] b, input logic h,
                             input logic m, input logic r,
                             inout int st, inout int sc, inout int bls, inout int tm);
      int ns, nsc, nbl, ntm;
      ns = st; nsc = sc; nbl = bls;
      ntm = (r && tm > 0) ? tm - 1 : tm;
      case (st)
         0: if (b != 0) begin ns = 1; nbl = bls - 1; end
         1: begin
            if (h) nsc = (sc + 1) % 100;
            if (m) begin
               if (bls == 0) ns = 3;
               else begin ns = 2; nbl = bls - 1; end
            end
         end
         2: if (tm == 0 && b != 0) ns = 1;
         default: if (tm == 0) begin ns = 0; nsc = 0; nbl = binit; end
      endcase
      if (ns != st && (ns == 2 || ns == 3)) ntm = ticks;
      st = ns; sc = nsc; bls = nbl; tm = ntm;
   endtask

   task automatic check_all();
      chk("a_state", int'(a_gs), a_st);
      chk("a_dig0",  int'(a_d0), a_sc % 10);
      chk("a_dig1",  int'(a_d1), a_sc / 10);
      chk("a_balls", int'(a_bl), a_bls);
      chk("a_still", int'(a_still), int'(a_st != 1));
      chk("a_rules", int'(a_rules), int'(a_st == 0));
      chk("a_over",  int'(a_over),  int'(a_st == 3));
      chk("b_state", int'(b_gs), b_st);
      chk("b_dig0",  int'(b_d0), b_sc % 10);
      chk("b_dig1",  int'(b_d1), b_sc / 10);
      chk("b_balls", int'(b_bl), b_bls);
      chk("b_still", int'(b_still), int'(b_st != 1));
      chk("b_rules", int'(b_rules), int'(b_st == 0));
      chk("b_over",  int'(b_over),  int'(b_st == 3));
   endtask

   // called at a negedge; applies inputs for one edge and checks the result at the next negedge
   task automatic cyc(input logic [1:0] b, input logic h, input logic m, input logic r);
      btn = b; hit = h; miss = m; refr_tick = r;
      @(posedge clk);
      model_step(120, 3, b, h, m, r, a_st, a_sc, a_bls, a_tm);
      model_step(1, 1, b, h, m, r, b_st, b_sc, b_bls, b_tm);
      @(negedge clk);
      check_all();
   endtask

   // asserts reset between edges and checks the outputs before any edge arrives
   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
      a_st = 0; a_sc = 0; a_bls = 3; a_tm = 0;
      b_st = 0; b_sc = 0; b_bls = 1; b_tm = 0;
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      check_all();
   endtask

   initial begin
      do_reset();

      // start game
      cyc(2'b01, 1'b0, 1'b0, 1'b0);
      chk("start_balls", int'(a_bl), 2);
      chk("start_still", int'(a_still), 0);

      // BCD counting through 10, 99 and wrap to 00
      for (int i = 0; i < 10; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
      chk("score10", int'({a_d1, a_d0}), 8'h10);
      for (int i = 0; i < 89; i++) begin
         cyc(2'b00, 1'b1, 1'b0, i[0]);
         chk("a_dig_range", int'(a_d0 <= 4'd9 && a_d1 <= 4'd9), 1);
      end
      chk("score99", int'({a_d1, a_d0}), 8'h99);
      cyc(2'b00, 1'b1, 1'b0, 1'b0);
      chk("score_wrap", int'({a_d1, a_d0}), 8'h00);

      // miss with balls 2 -> new ball, early press ignored, held press exits after the pause
      cyc(2'b00, 1'b0, 1'b1, 1'b1);
      chk("nb_balls", int'(a_bl), 1);
      for (int i = 0; i < 50; i++) cyc(2'b00, 1'b1, 1'b0, 1'b1);
      cyc(2'b10, 1'b0, 1'b0, 1'b1);
      chk("nb_early", int'(a_gs), 2);
      for (int i = 0; i < 400 && a_st != 1; i++) cyc(2'b11, 1'b0, 1'b0, 1'b1);
      chk("nb_exit", int'(a_gs), 1);

      // simultaneous hit+miss with balls 1
      cyc(2'b00, 1'b1, 1'b1, 1'b0);
      chk("hm_state", int'(a_gs), 2);
      chk("hm_balls", int'(a_bl), 0);
      chk("hm_score", int'({a_d1, a_d0}), 8'h01);
      for (int i = 0; i < 300 && a_st != 1; i++) cyc(2'b01, 1'b1, 1'b0, 1'($urandom_range(0, 1)));

      // game over with balls 0, then back to a fresh game
      cyc(2'b00, 1'b0, 1'b1, 1'b0);
      chk("go_en", int'(a_over), 1);
      for (int i = 0; i < 400 && a_st != 0; i++) cyc(2'b00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("go_balls", int'(a_bl), 3);
      chk("go_score", int'({a_d1, a_d0}), 0);

      // random play
      for (int i = 0; i < 4000; i++)
         cyc(($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 39) == 0),
             1'($urandom_range(0, 1)));

      // asynchronous reset mid-play with score 37
      do_reset();
      cyc(2'b01, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 37; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_score", int'({a_d1, a_d0}), 8'h37);
      do_reset();
      chk("rst_rules", int'(a_rules), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
